// File: rtl/pb_read_engine_if.sv
// Signal bundle for one port's read engine: descriptor input, packet-buffer
// request/return lanes and the outgoing word stream.
interface pb_read_engine_if #(
    parameter int asz     = 8,
    parameter int dsz     = 64,
    parameter int lsz     = 8,
    parameter int txid_sz = 2
);
    logic                       d_srdy;
    logic                       d_drdy;
    logic [asz-1:0]             d_addr;
    logic [lsz-1:0]             d_len;

    logic                       pbrd_srdy;
    logic                       pbrd_drdy;
    logic [txid_sz+dsz+asz:0]   pbrd_data;

    logic                       pbrr_srdy;
    logic                       pbrr_drdy;
    logic [dsz-1:0]             pbrr_data;

    logic                       p_srdy;
    logic                       p_drdy;
    logic [dsz-1:0]             p_data;
    logic                       p_eop;

    logic                       err;

    modport master (
        input  d_srdy, d_addr, d_len, pbrd_drdy, pbrr_srdy, pbrr_data, p_drdy,
        output d_drdy, pbrd_srdy, pbrd_data, pbrr_drdy, p_srdy, p_data, p_eop, err
    );

    modport slave (
        output d_srdy, d_addr, d_len, pbrd_drdy, pbrr_srdy, pbrr_data, p_drdy,
        input  d_drdy, pbrd_srdy, pbrd_data, pbrr_drdy, p_srdy, p_data, p_eop, err
    );
endinterface

// File: rtl/pb_read_engine.sv
// Per-port egress read engine: turns a (start address, length) descriptor into
// credit-limited single-word buffer reads and streams the returns out with EOP.
module pb_read_engine #(
    parameter int asz     = 8,
    parameter int dsz     = 64,
    parameter int lsz     = 8,
    parameter int txid_sz = 2,
    parameter int port_id = 0,
    parameter int credits = 4
) (
    input  logic               clk,
    input  logic               reset,
    pb_read_engine_if.master   bus
);

    localparam int pw = $clog2(credits);
    localparam int cw = $clog2(credits + 1);
    localparam logic [cw-1:0]      cred_max   = cw'(credits);
    localparam logic [pw:0]        fifo_full  = (pw+1)'(credits);
    localparam logic [txid_sz-1:0] port_field = txid_sz'(port_id);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               d_drdy_c;
    logic               pbrd_srdy_c;

    logic [asz-1:0]     cur_addr;
    logic [lsz-1:0]     remain;
    logic [cw-1:0]      credit;

    logic [credits-1:0] tag_mem;
    logic [pw-1:0]      tag_wr;
    logic [pw-1:0]      tag_rd;
    logic [pw:0]        tag_cnt;

    logic [dsz-1:0]     ret_data [credits];
    logic [credits-1:0] ret_eop;
    logic [pw-1:0]      ret_wr;
    logic [pw-1:0]      ret_rd;
    logic [pw:0]        ret_cnt;

    logic               err_q;

    logic               d_xfer;
    logic               rd_xfer;
    logic               rr_xfer;
    logic               rr_ok;
    logic               rr_bad;
    logic               p_srdy_c;
    logic               p_xfer;
    logic               cred_ovf;

    function automatic logic [pw:0] cnt_next(input logic [pw:0] cnt,
                                             input logic inc, input logic dec);
        logic [pw:0] r;
        r = cnt;
        if (inc && !dec)
            r = cnt + 1'b1;
        else if (dec && !inc)
            r = cnt - 1'b1;
        return r;
    endfunction

    // Handshake qualifiers; a return is only legal when a request is
    // outstanding and the return FIFO has room, which credits guarantee.
    assign d_xfer   = d_drdy_c && bus.d_srdy;
    assign rd_xfer  = pbrd_srdy_c && bus.pbrd_drdy;
    assign rr_xfer  = reset && bus.pbrr_srdy;
    assign rr_ok    = rr_xfer && (ret_cnt != fifo_full) && (tag_cnt != '0);
    assign rr_bad   = rr_xfer && !rr_ok;
    assign p_srdy_c = (ret_cnt != '0);
    assign p_xfer   = p_srdy_c && bus.p_drdy;
    assign cred_ovf = p_xfer && !rd_xfer && (credit == cred_max);

    always_comb begin
        state_nxt   = state;
        d_drdy_c    = 1'b0;
        pbrd_srdy_c = 1'b0;
        case (state)
            IDLE: begin
                d_drdy_c = 1'b1;
                if (bus.d_srdy)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                pbrd_srdy_c = (credit != '0);
                if (pbrd_srdy_c && bus.pbrd_drdy && remain == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            credit  <= cred_max;
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
            ret_wr  <= '0;
            ret_rd  <= '0;
            ret_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (rd_xfer && !p_xfer)
                credit <= credit - 1'b1;
            else if (p_xfer && !rd_xfer && !cred_ovf)
                credit <= credit + 1'b1;

            if (rd_xfer)
                tag_wr <= tag_wr + 1'b1;
            if (rr_ok)
                tag_rd <= tag_rd + 1'b1;
            tag_cnt <= cnt_next(tag_cnt, rd_xfer, rr_ok);

            if (rr_ok)
                ret_wr <= ret_wr + 1'b1;
            if (p_xfer)
                ret_rd <= ret_rd + 1'b1;
            ret_cnt <= cnt_next(ret_cnt, rr_ok, p_xfer);

            err_q <= err_q | rr_bad | cred_ovf;
        end
    end

    // Address/length and FIFO storage carry no reset: they are always
    // written before they are consumed.
    always_ff @(posedge clk) begin
        if (d_xfer) begin
            cur_addr <= bus.d_addr;
            remain   <= bus.d_len;
        end else if (rd_xfer) begin
            cur_addr <= cur_addr + 1'b1;
            if (remain != '0)
                remain <= remain - 1'b1;
        end

        if (rd_xfer)
            tag_mem[tag_wr] <= (remain == '0);

        if (rr_ok) begin
            ret_data[ret_wr] <= bus.pbrr_data;
            ret_eop[ret_wr]  <= tag_mem[tag_rd];
        end
    end

    assign bus.d_drdy    = d_drdy_c && reset;
    assign bus.pbrd_srdy = pbrd_srdy_c;
    assign bus.pbrd_data = {1'b0, port_field, {dsz{1'b0}}, cur_addr};
    assign bus.pbrr_drdy = reset;
    assign bus.p_srdy    = p_srdy_c;
    assign bus.p_data    = p_srdy_c ? ret_data[ret_rd] : '0;
    assign bus.p_eop     = p_srdy_c && ret_eop[ret_rd];
    assign bus.err       = err_q;

endmodule

// File: tb/tb_pb_read_engine.sv
// Bench for pb_read_engine: acts as scheduler, buffer and transmit sink, and
// compares every transfer with a queue-based model of descriptor expansion.
module tb_pb_read_engine;

    localparam int ASZ  = 8;
    localparam int DSZ  = 64;
    localparam int LSZ  = 8;
    localparam int TX   = 2;
    localparam int PORT = 2;
    localparam int CRED = 4;
    localparam int RW   = 1 + TX + DSZ + ASZ;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pb_read_engine_if #(.asz(ASZ), .dsz(DSZ), .lsz(LSZ), .txid_sz(TX)) bus ();

    pb_read_engine #(
        .asz(ASZ), .dsz(DSZ), .lsz(LSZ), .txid_sz(TX),
        .port_id(PORT), .credits(CRED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [ASZ-1:0] a;
        logic [LSZ-1:0] l;
    } desc_t;

    typedef struct {
        int             due;
        logic [ASZ-1:0] a;
    } ret_t;

    logic [DSZ-1:0] pb_mem [256];
    desc_t          desc_q [$];
    logic [ASZ-1:0] exp_addr_q [$];
    logic [DSZ:0]   exp_out_q [$];
    ret_t           pend_q [$];

    int issued, popped, returned, cyc;
    bit err_exp;
    int n_chk, n_pass;
    int rd_mode, p_mode, lat_lo, lat_hi;
    bit inject, inject_active;
    bit prev_stall;
    logic [RW-1:0] prev_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    function automatic bit model_idle();
        return desc_q.size() == 0 && exp_addr_q.size() == 0 &&
               exp_out_q.size() == 0 && pend_q.size() == 0;
    endfunction

    task automatic tick();
        logic          x_d, x_rd, x_rr, x_p;
        logic [RW-1:0] rq;
        logic [RW-1:0] exp_rq;
        logic [DSZ:0]  exp_w;
        desc_t         d;
        logic [ASZ-1:0] a;
        ret_t          r;
        int            lat;

        @(negedge clk);
        x_d  = bus.d_srdy && bus.d_drdy;
        x_rd = bus.pbrd_srdy && bus.pbrd_drdy;
        x_rr = bus.pbrr_srdy && bus.pbrr_drdy;
        x_p  = bus.p_srdy && bus.p_drdy;
        rq   = bus.pbrd_data;

        chk("d_drdy", bus.d_drdy, exp_addr_q.size() == 0);
        chk("pbrd_srdy", bus.pbrd_srdy, exp_addr_q.size() != 0 && (issued - popped) < CRED);
        chk("p_srdy", bus.p_srdy, (returned - popped) > 0);
        chk("err", bus.err, err_exp);
        if (prev_stall)
            chk("pbrd_hold", bus.pbrd_data, prev_data);
        if (x_rd) begin
            exp_rq = (exp_addr_q.size() != 0) ?
                     {1'b0, TX'(PORT), DSZ'(0), exp_addr_q[0]} : {RW{1'bx}};
            chk("pbrd_data", bus.pbrd_data, exp_rq);
        end
        if (x_p) begin
            exp_w = (exp_out_q.size() != 0) ? exp_out_q[0] : {(DSZ+1){1'bx}};
            chk("p_word", {bus.p_eop, bus.p_data}, exp_w);
        end
        prev_stall = bus.pbrd_srdy && !bus.pbrd_drdy;
        prev_data  = bus.pbrd_data;

        @(posedge clk);
        #1;
        cyc = cyc + 1;

        if (x_rd) begin
            if (exp_addr_q.size() != 0)
                void'(exp_addr_q.pop_front());
            issued = issued + 1;
            lat = $urandom_range(lat_lo, lat_hi);
            r.due = cyc + lat - 1;
            r.a   = rq[ASZ-1:0];
            pend_q.push_back(r);
        end
        if (x_d) begin
            d = desc_q.pop_front();
            for (int i = 0; i <= int'(d.l); i++) begin
                a = d.a + ASZ'(i);
                exp_addr_q.push_back(a);
                exp_out_q.push_back({(i == int'(d.l)), pb_mem[a]});
            end
        end
        if (x_rr) begin
            if (inject_active)
                err_exp = 1'b1;
            else begin
                if (pend_q.size() != 0)
                    void'(pend_q.pop_front());
                returned = returned + 1;
            end
        end
        if (x_p) begin
            if (exp_out_q.size() != 0)
                void'(exp_out_q.pop_front());
            popped = popped + 1;
        end

        bus.d_srdy = (desc_q.size() != 0);
        if (desc_q.size() != 0) begin
            bus.d_addr = desc_q[0].a;
            bus.d_len  = desc_q[0].l;
        end
        bus.pbrd_drdy = (rd_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.p_drdy    = (p_mode == 0) ? 1'b1 :
                        (p_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (inject) begin
            bus.pbrr_srdy = 1'b1;
            bus.pbrr_data = {$urandom, $urandom};
            inject_active = 1'b1;
            inject        = 1'b0;
        end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            bus.pbrr_srdy = 1'b1;
            bus.pbrr_data = pb_mem[pend_q[0].a];
            inject_active = 1'b0;
        end else begin
            bus.pbrr_srdy = 1'b0;
            inject_active = 1'b0;
        end
    endtask

    task automatic run(input int max_cycles);
        int n;
        n = 0;
        while (!model_idle() && n < max_cycles) begin
            tick();
            n = n + 1;
        end
        chk("drain_timeout", model_idle(), 1'b1);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        bus.d_srdy    = 1'b0;
        bus.d_addr    = '0;
        bus.d_len     = '0;
        bus.pbrd_drdy = 1'b0;
        bus.pbrr_srdy = 1'b0;
        bus.pbrr_data = '0;
        bus.p_drdy    = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_ctl", {bus.d_drdy, bus.pbrd_srdy, bus.pbrr_drdy, bus.p_srdy, bus.p_eop, bus.err}, 6'b0);
        chk("rst_pdata", bus.p_data, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        desc_q.delete();
        exp_addr_q.delete();
        exp_out_q.delete();
        pend_q.delete();
        issued = 0; popped = 0; returned = 0;
        err_exp = 1'b0; inject = 1'b0; inject_active = 1'b0; prev_stall = 1'b0;
        bus.pbrd_drdy = 1'b1;
        bus.p_drdy    = 1'b1;
    endtask

    initial begin
        desc_t dd;
        int    base;
        n_chk = 0; n_pass = 0; cyc = 0;
        rd_mode = 0; p_mode = 0; lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 256; i++)
            pb_mem[i] = {$urandom, $urandom};

        #2;
        do_reset();

        // Basic three-word packet, returns two cycles after each request
        dd.a = 8'h10; dd.l = 8'd2; desc_q.push_back(dd);
        run(100);

        // Credit stall: sink blocked, only four requests may issue
        p_mode = 1;
        base = issued;
        dd.a = 8'h20; dd.l = 8'd7; desc_q.push_back(dd);
        repeat (15) tick();
        chk("stall_reqs", issued - base, 4);
        chk("stall_srdy", bus.pbrd_srdy, 1'b0);
        p_mode = 0;
        run(200);

        // Address wrap
        dd.a = 8'hFE; dd.l = 8'd3; desc_q.push_back(dd);
        run(100);

        // Back-to-back descriptors
        dd.a = 8'h50; dd.l = 8'd0; desc_q.push_back(dd);
        dd.a = 8'h60; dd.l = 8'd1; desc_q.push_back(dd);
        run(100);

        // Randomized backpressure, latency and lengths, plus a maximum-length packet
        rd_mode = 1; p_mode = 2; lat_lo = 1; lat_hi = 4;
        for (int k = 0; k < 8; k++) begin
            dd.a = 8'($urandom);
            dd.l = 8'($urandom_range(0, 20));
            desc_q.push_back(dd);
        end
        dd.a = 8'($urandom); dd.l = 8'hFF; desc_q.push_back(dd);
        run(8000);

        // Spurious return with nothing outstanding
        rd_mode = 0; p_mode = 0; lat_lo = 2; lat_hi = 2;
        inject = 1'b1;
        repeat (5) tick();
        chk("err_sticky", bus.err, 1'b1);

        // Reset in the middle of a packet, then resume normal operation
        dd.a = 8'h80; dd.l = 8'd10; desc_q.push_back(dd);
        repeat (6) tick();
        do_reset();
        repeat (3) tick();
        dd.a = 8'h90; dd.l = 8'd1; desc_q.push_back(dd);
        run(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pb_read_engine.md
Name: pb_read_engine

Overview:
- Per-port egress read engine sitting between a port's transmit scheduler and the shared packet buffer.
- Takes a packet descriptor (start address, length) and issues single-word read requests on that port's pbrd channel, bounded by a credit count.
- Accepts in-order read returns on the port's pbrr lane and presents them as a word stream with end-of-packet marking to the port's transmit logic.
- One instance per port.

Parameters:
- asz, 8, packet buffer word-address width; address arithmetic wraps modulo 2^asz
- dsz, 64, data word width (matches packet buffer word)
- lsz, 8, descriptor length field width
- txid_sz, 2, port number width
- port_id, 0, this instance's port number, inserted in every request
- credits, 4, max words outstanding plus buffered; sets return FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- d_srdy  in  1  descriptor valid
- d_drdy  out  1  descriptor accepted
- d_addr  in  asz  first word address
- d_len  in  lsz  word count minus one (1..2^lsz words)
- pbrd_srdy  out  1  read request valid
- pbrd_drdy  in  1  request accepted by buffer arbiter
- pbrd_data  out  1+txid_sz+dsz+asz  packed {write=0, port_id, data=0, addr}, MSB→LSB
- pbrr_srdy  in  1  read return valid for this port
- pbrr_drdy  out  1  return accepted
- pbrr_data  in  dsz  read return word
- p_srdy  out  1  output word valid
- p_drdy  in  1  output word consumed
- p_data  out  dsz  output word
- p_eop  out  1  last word of packet
- err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, async): state IDLE. Credit counter = credits. Return FIFO and tag FIFO empty. err=0.
  - Outputs during reset: d_drdy=0, pbrd_srdy=0, pbrr_drdy=0, p_srdy=0, p_eop=0, p_data=0.
  - A reset mid-packet discards all in-flight state; late returns after reset are not a legal stimulus.
- Handshakes: srdy/drdy. A transfer occurs on any cycle where both are 1. Once srdy is high it stays high, with data stable, until the transfer.
- FSM IDLE:
  - d_drdy=1, pbrd_srdy=0.
  - On d_srdy: latch cur_addr=d_addr, remain=d_len; go to ISSUE.
- FSM ISSUE:
  - d_drdy=0; pbrd_srdy = (credit != 0); pbrd_data addr field = cur_addr.
  - On pbrd transfer: cur_addr+1 (wraps 2^asz-1→0), credit-1, push tag eop=(remain==0).
  - If remain==0, go to IDLE; otherwise remain-1.
  - First request is valid the cycle after descriptor acceptance. The next descriptor may be accepted the cycle after the last request issues, while earlier returns are still outstanding.
- pbrr_drdy = 1 whenever out of reset; credits guarantee FIFO space.
  - Return with FIFO full, or with the tag FIFO empty: set err, drop the word.
- Return FIFO (depth credits):
  - Push on pbrr transfer, paired with the popped tag.
  - p_srdy is registered and rises the cycle after the pbrr transfer.
  - p_eop is the tag for the head word.
- Credit:
  - +1 on p transfer, -1 on pbrd transfer; a simultaneous p transfer and pbrd transfer leaves credit unchanged.
  - Credit never exceeds credits; an attempted overflow sets err.
- Returns are in request order per port; no reordering logic.
- Length boundaries: d_len=0 → exactly one word, p_eop=1. d_len=2^lsz-1 → 2^lsz words.

Test Plan:
- Basic packet: reset, d_addr=0x10, d_len=2, all drdy=1, returns 2 cycles after each request → requests to 0x10, 0x11, 0x12 with port_id in the port field; p_data in the same order; p_eop=1 only on the third word.
- Credit stall: credits=4, p_drdy=0, d_len=7 → exactly 4 requests, then pbrd_srdy=0. Raise p_drdy → one new request per word popped; 8 words total, eop on the 8th.
- Wrap: asz=8, d_addr=0xFE, d_len=3 → addresses 0xFE, 0xFF, 0x00, 0x01.
- Back-to-back packets: two descriptors (len 0, then len 1) presented continuously → second accepted the cycle after the first's request issues; output words 1, 2, 3 with eop on words 1 and 3.
- Arbiter backpressure: pbrd_drdy toggled 0/1 randomly → pbrd_data stable while stalled; no request lost or duplicated.
- Error and reset: pbrr_srdy with nothing outstanding → err=1 and sticky. Assert reset mid-packet → all outputs to reset values immediately; after release d_drdy=1 and err=0.
